hs_responder: RTL
=================

# hs_responder

Receiving end of the four-phase req/ack bundled-data handshake used between GALS stages. It synchronises a `req_in` arriving from a foreign clock domain, captures `data_in` into a small FIFO, and drives `ack_out` back through the full four-phase cycle. It presents captured words to the local stage on a valid/ready port. It sits at the input of any stage (ID, ALU, WB, register file) that is fed by a sender-side req FSM.

## Interface
- `DATA_W`, default 16: width of the bundled data word.
- `SYNC_STAGES`, default 2: flops in the `req_in` synchroniser. Minimum 2.
- `DEPTH`, default 2: FIFO entries. Power of two, at least 2.
- `clk`  in  1  local clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req_in`  in  1  request from the remote domain. Asynchronous to `clk`.
- `data_in`  in  DATA_W  bundled data. Stable from `req_in` rise until `ack_out` rises.
- `ack_out`  out  1  acknowledge to the remote domain. Registered and glitch-free.
- `out_valid`  out  1  the FIFO head is valid.
- `out_data`  out  DATA_W  the FIFO head word.
- `out_ready`  in  1  the local consumer accepts the head word.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `xfer_cnt`  out  16  number of completed captures. Wraps modulo 2^16.

## Operation
- `req_s` is `req_in` passed through SYNC_STAGES flops. Only `req_s` is used internally.
- The FSM has two states, IDLE and ACK_HI.
- **IDLE.** `ack_out` is 0.
  - If `req_s` is 1 and `count` is less than DEPTH: push `data_in`, set `ack_out` to 1, increment `xfer_cnt`, go to ACK_HI.
  - If `req_s` is 1 and the FIFO is full: stay in IDLE and do not assert `ack_out`. Back-pressure reaches the sender only by withholding ack.
- **ACK_HI.** `ack_out` is 1.
  - When `req_s` is 0: clear `ack_out` and go to IDLE.
  - Any other input leaves the state unchanged.
- **FIFO.**
  - `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits, including a wrap bit.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the remaining bits are equal.
  - Pop happens when `out_valid` and `out_ready` are both high.
  - `out_data` is the memory entry at `rd_ptr`. There is no write-to-read bypass.
- **Simultaneous push and pop.**
  - Both occur in the same cycle and `count` is unchanged.
  - The full check uses the registered `count`, so a pop does not free space in the same cycle for a push.
- **Popping when empty** (`out_ready` high with `out_valid` low) is ignored.
- **Reset values.** `ack_out`=0, `out_valid`=0, `count`=0, `xfer_cnt`=0, `out_data`=0, state IDLE, and all synchroniser flops 0.
- **Reset mid-transfer.**
  - `ack_out` drops asynchronously and the FIFO contents are discarded.
  - If `req_in` is still high after reset releases, that request is captured again as a new transfer.
  - Sender and responder must therefore be reset together.

## Timing
- Capture latency: a `req_in` rise first sampled at edge k sets `ack_out`, pushes the word and increments `count` at edge k+SYNC_STAGES.
- `out_valid` rises one edge after the push into an empty FIFO, at edge k+SYNC_STAGES+1.
- Release latency: a `req_in` fall first sampled at edge m clears `ack_out` at edge m+SYNC_STAGES.
- `data_in` is sampled on the push edge. The bundled-data rule holds because `req_in` has already been stable for at least SYNC_STAGES cycles by then.
- Throughput: at most one word per round trip, which is at least 2·(SYNC_STAGES+1) local cycles plus the sender's synchroniser delay.
- Pop: `out_data` and `out_valid` update on the edge after the pop handshake.
- All outputs are registered. No combinational path exists from `req_in` or `out_ready` to any output.

## Structure
- Shared package `gals_pkg`:
  - `hs_state_t` enum (IDLE, ACK_HI).
  - `GALS_DATA_W` = 16.
  - `GALS_SYNC_STAGES` = 2.
  - The sender-side FSMs use the same constants.
- Sub-module `hs_sync`: a parameterised N-flop single-bit synchroniser with asynchronous active-low reset. It is reused for the sender's `ack` path.
- The FIFO is inline, with a register array and pointers. It is not a separate module.

## Test plan
- Single transfer, sender `data_in`=16'hA5C3:
  - `ack_out` rises exactly SYNC_STAGES edges after `req_in` is first sampled.
  - `out_data`=16'hA5C3 with `out_valid`=1 one edge later.
  - `xfer_cnt`=1.
  - `ack_out` falls SYNC_STAGES edges after `req_in` falls.
- Back-pressure, DEPTH=2, `out_ready`=0, three requests with words 1, 2, 3:
  - Words 1 and 2 are acknowledged and `count`=2.
  - The third `req_in` stays unacknowledged.
  - Raising `out_ready` for one cycle pops 1, then word 3 is acknowledged and `count` returns to 2.
- Simultaneous push and pop with `count`=1 and `out_ready` held high:
  - `count` stays 1.
  - Words emerge in order with no loss.
- Pointer wrap: stream 20 sequential words 0–19 with random `out_ready`:
  - All 20 arrive in order.
  - `xfer_cnt`=20.
  - `count` never exceeds 2.
- Reset asserted while in ACK_HI with `count`=1:
  - `ack_out`, `out_valid` and `count` go to 0 immediately, without waiting for a clock edge.
  - After release with `req_in` still high, a new capture occurs and `xfer_cnt`=1.
- Asynchronous sender on a clock unrelated to `clk` (for example 37 ns against 10 ns), 1000 transfers:
  - Scoreboard matches every word.
  - There are no duplicate or dropped transfers.

Source files
------------

// File: rtl/gals_pkg.sv
// Shared constants and state type for the GALS bundled-data handshake.
// Sender-side FSMs and the responder both build on these.
package gals_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACK_HI = 1'b1
    } hs_state_t;

    localparam int GALS_DATA_W      = 16;
    localparam int GALS_SYNC_STAGES = 2;

endpackage

// File: rtl/hs_sync.sv
// N-flop single-bit synchroniser with async active-low reset.
// Used for req on the responder side and for ack on the sender side.
module hs_sync #(
    parameter int N = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/hs_responder.sv
// Four-phase req/ack responder: synchronises req, captures data into a
// small FIFO and presents it on a registered valid/ready port.
module hs_responder
    import gals_pkg::*;
#(
    parameter int DATA_W      = GALS_DATA_W,
    parameter int SYNC_STAGES = GALS_SYNC_STAGES,
    parameter int DEPTH       = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_in,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     ack_out,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              xfer_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic              w_req_s;
    logic              w_push;
    logic              w_pop;
    logic [AW:0]       w_rd_next;

    hs_state_t         r_state;
    logic              r_ack;
    logic [15:0]       r_xfer;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    hs_sync #(
        .N (SYNC_STAGES)
    ) u_req_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (req_in),
        .o_q     (w_req_s)
    );

    // Full check is on the registered count: a same-cycle pop never
    // makes room for a push.
    assign w_push    = (r_state == IDLE) && w_req_s
                       && (r_count < FULL_CNT);
    assign w_pop     = r_out_valid && out_ready;
    assign w_rd_next = w_pop ? r_rd_ptr + ONE : r_rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_xfer  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_push) begin
                        r_ack   <= 1'b1;
                        r_xfer  <= r_xfer + 16'd1;
                        r_state <= ACK_HI;
                    end
                end
                ACK_HI: begin
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_in;
        end
    end

    // Head view uses the post-pop read pointer but the pre-push write
    // pointer, so a fresh word shows up one edge after its push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ONE;
            end
            r_rd_ptr <= w_rd_next;
            if (w_push && !w_pop) begin
                r_count <= r_count + ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - ONE;
            end
            r_out_valid <= (r_wr_ptr != w_rd_next);
            if (r_wr_ptr != w_rd_next) begin
                r_out_data <= r_mem[w_rd_next[AW-1:0]];
            end
        end
    end

    assign ack_out   = r_ack;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign count     = r_count;
    assign xfer_cnt  = r_xfer;

endmodule
